// File: rtl/display_scan_scheduler.sv
// -----------------------------------------------------------------------------
// display_scan_scheduler
//   Time-multiplexes NUM_DIGITS hex digits onto one shared seven-segment
//   decoder. Each enabled digit owns the decoder for ON_CYCLES clocks. When
//   blanking is built in, DEAD_CYCLES clocks of all-off time separate slots.
//
// Build option:
//   DISPLAY_SCAN_DEADTIME_EN  defined   -> SCAN slot, DEAD blanking, next slot
//                             undefined -> SCAN slots back to back
//
// Parameters:
//   NUM_DIGITS   number of multiplexed digits (2..4)
//   ON_CYCLES    clocks per digit on-slot (>= 2)
//   DEAD_CYCLES  clocks of blanking between slots (>= 1)
//
// Ports:
//   clk         clock, rising edge
//   reset       synchronous active-high reset, overrides everything
//   digits      packed digit values, digit i at [4i+3:4i]
//   digit_en    per-digit scan participation
//   hold        freeze scan position, counters and anodes
//   hex         registered value for the shared decoder
//   anode_n     registered active-low digit enables (at most one low)
//   active_idx  index of the digit that currently owns the decoder
//   slot_start  one-cycle pulse on the first cycle of each on-slot
// -----------------------------------------------------------------------------
module display_scan_scheduler #(
  parameter int unsigned NUM_DIGITS  = 2,
  parameter int unsigned ON_CYCLES   = 20000,
  parameter int unsigned DEAD_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    hold,
  output logic [3:0]              hex,
  output logic [NUM_DIGITS-1:0]   anode_n,
  output logic [1:0]              active_idx,
  output logic                    slot_start
);

  localparam int unsigned MAX_CYCLES = (ON_CYCLES > DEAD_CYCLES) ? ON_CYCLES : DEAD_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [0:0] ST_SCAN = 1'b0;
  localparam logic [0:0] ST_DEAD = 1'b1;

  localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);

  // Scan position of the current cycle
  logic [0:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            idx_q, idx_d;
  // Low only between reset and the first scheduled slot
  logic                  run_q, run_d;

  // Registered outputs
  logic [3:0]            hex_q, hex_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic                  slot_start_q, slot_start_d;

  // Result of the cyclic search for the next enabled digit
  logic [1:0]            next_idx;
  logic                  found;

  // Cyclic search from idx_q+1; wraps around to idx_q itself, so an
  // only-current or all-disabled enable mask leaves the index unchanged
  always_comb begin : next_idx_search
    next_idx = idx_q;
    found    = 1'b0;
    for (int k = 1; k <= int'(NUM_DIGITS); k++) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        if (!found && digit_en[i] &&
            (i == (int'(idx_q) + k) % int'(NUM_DIGITS))) begin
          next_idx = 2'(i);
          found    = 1'b1;
        end
      end
    end
  end

  // Next scan position and registered output values
  always_comb begin : next_state
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    run_d        = 1'b1;
    slot_start_d = 1'b0;
    hex_d        = 4'h0;
    anode_d      = '1;

    if (!run_q) begin
      // First edge out of reset opens the slot of digit 0
      state_d      = ST_SCAN;
      cnt_d        = '0;
      idx_d        = 2'd0;
      slot_start_d = 1'b1;
    end else if (!hold) begin
      case (state_q)
        ST_SCAN: begin
          if (cnt_q == ON_LAST) begin
            idx_d = next_idx;
            cnt_d = '0;
`ifdef DISPLAY_SCAN_DEADTIME_EN
            state_d      = ST_DEAD;
`else
            state_d      = ST_SCAN;
            slot_start_d = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DEAD: begin
          if (cnt_q == DEAD_LAST) begin
            state_d      = ST_SCAN;
            cnt_d        = '0;
            slot_start_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_SCAN;
          cnt_d   = '0;
        end
      endcase
    end

    // Decoder follows the owning digit every cycle, including blanking
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (idx_d == 2'(i)) begin
        hex_d = digits[4*i +: 4];
      end
    end

    // Anodes freeze under hold; otherwise light only the enabled owner in SCAN
    if (run_q && hold) begin
      anode_d = anode_q;
    end else begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        anode_d[i] = !((state_d == ST_SCAN) && (idx_d == 2'(i)) && digit_en[i]);
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin : regs
    if (reset) begin
      state_q      <= ST_SCAN;
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      run_q        <= 1'b0;
      hex_q        <= 4'h0;
      anode_q      <= '1;
      slot_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      run_q        <= run_d;
      hex_q        <= hex_d;
      anode_q      <= anode_d;
      slot_start_q <= slot_start_d;
    end
  end

  assign hex        = hex_q;
  assign anode_n    = anode_q;
  assign active_idx = idx_q;
  assign slot_start = slot_start_q;

endmodule

// File: tb/tb_display_scan_scheduler.sv
module tb_display_scan_scheduler;

  localparam int ND   = 2;
  localparam int ON   = 4;
  localparam int DEAD = 2;
`ifdef DISPLAY_SCAN_DEADTIME_EN
  localparam int PERIOD = ON + DEAD;
  localparam int ADV_PH = ON;
`else
  localparam int PERIOD = ON;
  localparam int ADV_PH = 0;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] digits;
  logic [1:0] digit_en;
  logic       hold;
  logic [3:0] hex;
  logic [1:0] anode_n;
  logic [1:0] active_idx;
  logic       slot_start;

  int checks = 0;
  int errors = 0;

  display_scan_scheduler #(
    .NUM_DIGITS (ND),
    .ON_CYCLES  (ON),
    .DEAD_CYCLES(DEAD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .digits    (digits),
    .digit_en  (digit_en),
    .hold      (hold),
    .hex       (hex),
    .anode_n   (anode_n),
    .active_idx(active_idx),
    .slot_start(slot_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: elapsed un-held cycles since the first slot
  bit         m_started;
  int         m_t;
  int         m_idx;
  logic [1:0] m_anode;
  logic [3:0] m_hex;
  logic       m_ss;

  function automatic int pick_next(int cur, logic [1:0] en);
    for (int k = 1; k <= ND; k++) begin
      int j;
      j = (cur + k) % ND;
      if (((en >> j) & 2'b01) != 2'b00) return j;
    end
    return cur;
  endfunction

  task automatic model_edge();
    bit was_started;
    int ph;
    was_started = m_started;
    if (reset) begin
      m_started = 0;
      m_t       = 0;
      m_idx     = 0;
      m_anode   = 2'b11;
      m_hex     = 4'h0;
      m_ss      = 1'b0;
    end else begin
      if (!m_started) begin
        m_started = 1;
        m_t       = 0;
        m_idx     = 0;
        m_ss      = 1'b1;
      end else if (hold) begin
        m_ss = 1'b0;
      end else begin
        m_t++;
        ph = m_t % PERIOD;
        if (ph == ADV_PH) m_idx = pick_next(m_idx, digit_en);
        m_ss = (ph == 0);
      end
      m_hex = 4'((digits >> (4 * m_idx)) & 8'h0F);
      if (!(was_started && hold)) begin
        if ((m_t % PERIOD) < ON && (((digit_en >> m_idx) & 2'b01) != 2'b00))
          m_anode = ~(2'b01 << m_idx);
        else
          m_anode = 2'b11;
      end
    end
  endtask

  task automatic check_val(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    check_val("anode_n", int'(anode_n), int'(m_anode));
    check_val("hex", int'(hex), int'(m_hex));
    check_val("active_idx", int'(active_idx), m_idx);
    check_val("slot_start", int'(slot_start), int'(m_ss));
    check_val("anode_single_low", int'($countones(~anode_n) <= 1), 1);
  endtask

  task automatic step(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      check_model();
    end
  endtask

  typedef struct {
    logic       rst;
    logic [7:0] dig;
    logic [1:0] en;
    logic       hld;
    logic [1:0] exp_anode;
    logic [3:0] exp_hex;
    logic [1:0] exp_idx;
    logic       exp_ss;
  } vec_t;

  vec_t vecs[$];

  task automatic add_rep(int n, logic r, logic [7:0] d, logic [1:0] e, logic h,
                         logic [1:0] a, logic [3:0] x, logic [1:0] ix, logic s);
    vec_t v;
    v.rst = r; v.dig = d; v.en = e; v.hld = h;
    v.exp_anode = a; v.exp_hex = x; v.exp_idx = ix; v.exp_ss = s;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  initial begin
    reset    = 1'b1;
    digits   = 8'h00;
    digit_en = 2'b00;
    hold     = 1'b0;

    // Reset for 3 cycles, then one full scan period of 8'h5A with both enabled
    add_rep(3, 1'b1, 8'h5A, 2'b11, 1'b0, 2'b11, 4'h0, 2'd0, 1'b0);
    add_rep(1, 1'b0, 8'h5A, 2'b11, 1'b0, 2'b10, 4'hA, 2'd0, 1'b1);
    add_rep(3, 1'b0, 8'h5A, 2'b11, 1'b0, 2'b10, 4'hA, 2'd0, 1'b0);
`ifdef DISPLAY_SCAN_DEADTIME_EN
    add_rep(2, 1'b0, 8'h5A, 2'b11, 1'b0, 2'b11, 4'h5, 2'd1, 1'b0);
    add_rep(1, 1'b0, 8'h5A, 2'b11, 1'b0, 2'b01, 4'h5, 2'd1, 1'b1);
    add_rep(3, 1'b0, 8'h5A, 2'b11, 1'b0, 2'b01, 4'h5, 2'd1, 1'b0);
    add_rep(2, 1'b0, 8'h5A, 2'b11, 1'b0, 2'b11, 4'hA, 2'd0, 1'b0);
    add_rep(1, 1'b0, 8'h5A, 2'b11, 1'b0, 2'b10, 4'hA, 2'd0, 1'b1);
`else
    add_rep(1, 1'b0, 8'h5A, 2'b11, 1'b0, 2'b01, 4'h5, 2'd1, 1'b1);
    add_rep(3, 1'b0, 8'h5A, 2'b11, 1'b0, 2'b01, 4'h5, 2'd1, 1'b0);
    add_rep(1, 1'b0, 8'h5A, 2'b11, 1'b0, 2'b10, 4'hA, 2'd0, 1'b1);
    add_rep(3, 1'b0, 8'h5A, 2'b11, 1'b0, 2'b10, 4'hA, 2'd0, 1'b0);
`endif

    foreach (vecs[i]) begin
      reset    = vecs[i].rst;
      digits   = vecs[i].dig;
      digit_en = vecs[i].en;
      hold     = vecs[i].hld;
      @(posedge clk);
      model_edge();
      #1;
      check_val("tbl_anode_n", int'(anode_n), int'(vecs[i].exp_anode));
      check_val("tbl_hex", int'(hex), int'(vecs[i].exp_hex));
      check_val("tbl_active_idx", int'(active_idx), int'(vecs[i].exp_idx));
      check_val("tbl_slot_start", int'(slot_start), int'(vecs[i].exp_ss));
    end

    // Only digit 0 enabled: index never moves
    reset = 1'b1; step(2);
    reset = 1'b0; digit_en = 2'b01; digits = 8'h3C;
    step(14);

    // Hold for 10 cycles at slot count 1, then release
    reset = 1'b1; step(1);
    reset = 1'b0; digit_en = 2'b11; digits = 8'h91;
    step(2);
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      digits = 8'(digits + 8'h11);
      step(1);
      check_val("hold_anode", int'(anode_n), 2'b10);
    end
    hold = 1'b0;
    step(9);

    // No digit enabled, then digit 0 dropped mid-slot
    digit_en = 2'b00; step(10);
    reset = 1'b1; step(1);
    reset = 1'b0; digit_en = 2'b11; step(2);
    digit_en = 2'b10;
    step(1);
    check_val("drop_anode", int'(anode_n), 2'b11);
    step(8);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset  = ($urandom_range(0, 99) == 0);
      hold   = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) digit_en = 2'($urandom);
      if ($urandom_range(0, 2) == 0) digits = 8'($urandom);
      step(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_scan_scheduler.md
DISPLAY_SCAN_SCHEDULER -- requirements
Module: display_scan_scheduler

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 2: number of time-multiplexed digits sharing one seven-segment decoder (legal 2-4).
REQ-002 SHALL have parameter ON_CYCLES, default 20000: clk cycles per digit on-slot (legal >= 2).
REQ-003 SHALL have parameter DEAD_CYCLES, default 4: clk cycles of all-off blanking between slots (legal >= 1).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port digits, input, 4*NUM_DIGITS bits: digit i value at [4i+3:4i].
REQ-007 SHALL have port digit_en, input, NUM_DIGITS bits: 1 = digit i participates in scan.
REQ-008 SHALL have port hold, input, 1 bit: 1 = freeze scan state and counters.
REQ-009 SHALL have port hex, output, 4 bits: value driven to the shared decoder.
REQ-010 SHALL have port anode_n, output, NUM_DIGITS bits: active-low digit enables.
REQ-011 SHALL have port active_idx, output, 2 bits: index of digit currently owning the decoder.
REQ-012 SHALL have port slot_start, output, 1 bit: one-cycle pulse on first cycle of each on-slot.

Function
REQ-013 SHALL implement states SCAN and DEAD; DEAD exists only per REQ-027.
REQ-014 SHALL, in SCAN, count slot cycles 0..ON_CYCLES-1; at terminal count advance active_idx and enter DEAD (or a new SCAN slot per REQ-028), counter cleared.
REQ-015 SHALL, in DEAD, count 0..DEAD_CYCLES-1, then enter SCAN with counter 0 and pulse slot_start that cycle.
REQ-016 SHALL select next index as first i with digit_en[i]=1 searching cyclically from active_idx+1, wrapping NUM_DIGITS-1 -> 0; if only current digit enabled, index unchanged; if none enabled, index unchanged.
REQ-017 SHALL register all outputs; hex = digits slice of active_idx, updated every cycle (1-cycle latency from digits change), including during DEAD so decoder settles before anode turns on.
REQ-018 SHALL drive anode_n[active_idx]=0 only in SCAN with digit_en[active_idx]=1; all other bits 1; never more than one bit 0.
REQ-019 SHALL force all anode_n high within one cycle when digit_en[active_idx] drops mid-slot; slot timing continues unchanged.
REQ-020 SHALL, with digit_en all zero, keep anode_n all ones, keep cycling slots, hold active_idx.
REQ-021 SHALL, while hold=1, freeze state, counters, active_idx and anode_n; slot_start=0; hex still tracks digits; on release resume with remaining count.
REQ-022 SHALL give reset priority over hold and all other inputs.

Reset
REQ-023 SHALL, while reset=1 at a clock edge, set state SCAN, counter 0, active_idx 0, anode_n all ones, hex 0, slot_start 0.
REQ-024 SHALL, on first edge with reset=0, begin slot of digit 0: anode_n[0]=0 if digit_en[0]=1, slot_start=1.
REQ-025 SHALL treat reset mid-slot or mid-DEAD identically to REQ-023; no partial slot completed.

Configuration
REQ-026 SHALL gate blanking with macro DISPLAY_SCAN_DEADTIME_EN.
REQ-027 SHALL, with DISPLAY_SCAN_DEADTIME_EN defined, insert DEAD of DEAD_CYCLES between every pair of slots (scan period per enabled digit = ON_CYCLES+DEAD_CYCLES).
REQ-028 SHALL, without it, transition SCAN terminal count directly to next SCAN slot (period per digit = ON_CYCLES), DEAD_CYCLES unused, anode switch on a single edge.

Verification (NUM_DIGITS=2, ON_CYCLES=4, DEAD_CYCLES=2)
REQ-029 SHALL cover: reset high 3 cycles -> anode_n=2'b11, hex=0, active_idx=0; first edge after release -> anode_n=2'b10, slot_start=1.
REQ-030 SHALL cover: digits=8'h5A, digit_en=2'b11, DEADTIME_EN defined -> hex=A with anode_n=10 for 4 cycles, anode_n=11 for 2 cycles with hex=5, anode_n=01 for 4 cycles; 12-cycle period.
REQ-031 SHALL cover: digit_en=2'b01 -> active_idx stays 0; anode_n 10 for 4 cycles, 11 for 2 cycles, repeating.
REQ-032 SHALL cover: digit_en=2'b00 -> anode_n=11 every cycle; digit_en dropped mid-slot -> anode_n=11 next cycle, slot ends on schedule.
REQ-033 SHALL cover: hold=1 for 10 cycles at slot count 1 -> anode_n and active_idx constant; after release 3 more on-cycles before DEAD.
REQ-034 SHALL cover: DEADTIME_EN undefined, digit_en=2'b11 -> anode_n alternates 10/01 every 4 cycles, never 11; 8-cycle period.
